// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parametrised serial pattern detector.
// Optional counter feature is selected with SEQDET_COUNT_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } seq_state_t;

  localparam int SEQ_PATTERN_W_MAX = 16;
  localparam int SEQ_PATTERN_W_MIN = 2;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// Built only when SEQDET_COUNT_EN is defined.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime pattern, overlap mode select.
// Define SEQDET_COUNT_EN to add count_clr/count and the saturating counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PATTERN_W = 4,
  parameter bit OVERLAP   = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic                 in_valid,
  input  logic                 in_bit,
`ifdef SEQDET_COUNT_EN
  input  logic                 count_clr,
`endif
  output logic                 detect,
  output logic                 armed
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0]     count
`endif
);

  localparam int FW = $clog2(PATTERN_W);
  localparam logic [FW-1:0] LAST = FW'(PATTERN_W - 1);

  if (PATTERN_W < SEQ_PATTERN_W_MIN ||
      PATTERN_W > SEQ_PATTERN_W_MAX ||
      CNT_W < 1) begin : g_bad_cfg
    $error("seq_detector_param: illegal parameters");
  end

  seq_state_t           state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] win_q, win_d;
  logic [PATTERN_W-1:0] win_sh;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 match;

  assign win_sh = {win_q[PATTERN_W-2:0], in_bit};

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    win_d   = win_q;
    fill_d  = fill_q;
    match   = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          pat_d   = pattern_i;
          win_d   = '0;
          fill_d  = '0;
          state_d = FILL;
        end
        FILL: begin
          if (in_valid) begin
            win_d = win_sh;
            if (fill_q == LAST) begin
              state_d = ARMED;
              match   = (win_sh == pat_q);
            end else begin
              fill_d = fill_q + FW'(1);
            end
          end
        end
        ARMED: begin
          if (in_valid) begin
            win_d = win_sh;
            match = (win_sh == pat_q);
          end
        end
        default: state_d = IDLE;
      endcase
      // Non-overlapping mode discards the window after a hit.
      if (match && !OVERLAP) begin
        state_d = FILL;
        fill_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      detect  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      detect  <= match;
      armed   <= (state_d == ARMED);
    end
  end

`ifdef SEQDET_COUNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (match),
    .clr    (count_clr),
    .count  (count)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: four detector configurations share one input stream,
// checked against a queue-of-bits reference model.
module tb_seq_detector_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        in_valid;
  logic        in_bit;
  logic        count_clr;
  logic [15:0] pat;

  logic [3:0]  det;
  logic [3:0]  arm;
  logic [7:0]  cnt;

  typedef struct packed {
    logic [3:0] det;
    logic [3:0] arm;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int pws[4] = '{4, 4, 2, 2};
  int ovs[4] = '{1, 0, 1, 0};

  bit          act[4];
  logic [15:0] lat[4];
  bit          hq[4][$];
  int          cntm[4];

  always #5 clk = ~clk;

`ifdef SEQDET_COUNT_EN
  logic [1:0] c0, c1, c2, c3;
  assign cnt = {c3, c2, c1, c0};
`else
  assign cnt = '0;
`endif

  seq_detector_param #(.PATTERN_W(4), .OVERLAP(1'b1), .CNT_W(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .pattern_i(pat[3:0]),
    .in_valid(in_valid), .in_bit(in_bit),
`ifdef SEQDET_COUNT_EN
    .count_clr(count_clr), .count(c0),
`endif
    .detect(det[0]), .armed(arm[0]));

  seq_detector_param #(.PATTERN_W(4), .OVERLAP(1'b0), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .pattern_i(pat[3:0]),
    .in_valid(in_valid), .in_bit(in_bit),
`ifdef SEQDET_COUNT_EN
    .count_clr(count_clr), .count(c1),
`endif
    .detect(det[1]), .armed(arm[1]));

  seq_detector_param #(.PATTERN_W(2), .OVERLAP(1'b1), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .pattern_i(pat[1:0]),
    .in_valid(in_valid), .in_bit(in_bit),
`ifdef SEQDET_COUNT_EN
    .count_clr(count_clr), .count(c2),
`endif
    .detect(det[2]), .armed(arm[2]));

  seq_detector_param #(.PATTERN_W(2), .OVERLAP(1'b0), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .pattern_i(pat[1:0]),
    .in_valid(in_valid), .in_bit(in_bit),
`ifdef SEQDET_COUNT_EN
    .count_clr(count_clr), .count(c3),
`endif
    .detect(det[3]), .armed(arm[3]));

  // Reference: remember the accepted bits since the last (re)start and
  // compare the newest PATTERN_W of them with the latched pattern.
  function automatic exp_t model(input logic e, input logic v,
                                 input logic b, input logic c);
    exp_t        ex;
    logic [15:0] val;
    logic [15:0] mask;
    bit          d;
    ex = '0;
    for (int i = 0; i < 4; i++) begin
      d = 1'b0;
      if (!e) begin
        act[i] = 1'b0;
        hq[i].delete();
      end else if (!act[i]) begin
        act[i] = 1'b1;
        lat[i] = pat;
        hq[i].delete();
      end else if (v) begin
        hq[i].push_back(b);
        if (hq[i].size() > pws[i]) void'(hq[i].pop_front());
        if (hq[i].size() == pws[i]) begin
          val = '0;
          for (int k = 0; k < pws[i]; k++) val = {val[14:0], hq[i][k]};
          mask = (16'h1 << pws[i]) - 16'h1;
          if (val == (lat[i] & mask)) begin
            d = 1'b1;
            if (ovs[i] == 0) hq[i].delete();
          end
        end
      end
      ex.det[i] = d;
      ex.arm[i] = act[i] && (hq[i].size() == pws[i]);
      if (c) cntm[i] = 0;
      else if (d && cntm[i] < 3) cntm[i] = cntm[i] + 1;
      ex.cnt[2*i +: 2] = 2'(cntm[i]);
    end
    return ex;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      act[i]  = 1'b0;
      cntm[i] = 0;
      hq[i].delete();
    end
  endfunction

  task automatic cyc(input logic e, input logic v,
                     input logic b, input logic c);
    exp_t ex;
    en = e;
    in_valid = v;
    in_bit = b;
    count_clr = c;
    ex = model(e, v, b, c);
    @(posedge clk);
    sb.push_back(ex);
    #1;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input int gap);
    for (int k = n - 1; k >= 0; k--) begin
      cyc(1'b1, 1'b1, bits[k], 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    sb.push_back('0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      checks++;
      if (det !== ex.det) begin
        errors++;
        $display("FAIL detect t=%0t got=%b want=%b", $time, det, ex.det);
      end
      checks++;
      if (arm !== ex.arm) begin
        errors++;
        $display("FAIL armed t=%0t got=%b want=%b", $time, arm, ex.arm);
      end
`ifdef SEQDET_COUNT_EN
      checks++;
      if (cnt !== ex.cnt) begin
        errors++;
        $display("FAIL count t=%0t got=%h want=%h", $time, cnt, ex.cnt);
      end
`endif
    end
  end

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    count_clr = 1'b0;
    pat = 16'h000D;
    model_reset();
    #1;
    sb.push_back('0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1101 stream, back-to-back
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send(32'b1101101, 7, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // pattern 11, stream 111
    pat = 16'h0003;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send(32'b111, 3, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // 1101 stream with three bubbles after each bit
    pat = 16'h000D;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send(32'b1101101, 7, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-stream, then a single bit
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send(32'b110, 3, 0);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // five overlapping hits; clear lands on the fifth
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send(32'b110110110110110, 15, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 29) == 0) pat = 16'($urandom);
        cyc(1'($urandom_range(0, 49) != 0),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0));
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the successor to the fixed two-ones Moore detector.
- Runtime-loadable pattern of `PATTERN_W` bits.
- `in_valid` qualifier on the input stream.
- Selectable overlapping or non-overlapping match mode.
- Optional saturating detection counter.
- Sits on a serial input stream; it raises a one-cycle registered `detect` pulse on each match for downstream control logic.

## Interface
- `PATTERN_W`, 4: pattern length in bits, legal range 2..16.
- `OVERLAP`, 1: 1 means a match's trailing bits may start the next match; 0 means the window restarts after each match.
- `CNT_W`, 8: width of the detection counter. Used only with `SEQDET_COUNT_EN`.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous active-low reset.
- `en` input 1: detector enable. While low, the block is held in IDLE.
- `pattern_i` input PATTERN_W: target pattern. Bit `PATTERN_W-1` is the first bit received. Latched on entry from IDLE.
- `in_valid` input 1: `in_bit` is sampled only when this is high.
- `in_bit` input 1: serial data bit.
- `count_clr` input 1: synchronous clear of `count`. Present only with `SEQDET_COUNT_EN`.
- `detect` output 1: registered match pulse, one cycle wide.
- `armed` output 1: high in ARMED, meaning the window holds `PATTERN_W` valid bits.
- `count` output CNT_W: saturating detection count. Present only with `SEQDET_COUNT_EN`.

## Operation
- Internal registers:
  - `pat_q[PATTERN_W-1:0]`: latched pattern.
  - `win_q[PATTERN_W-1:0]`: shift window.
  - `fill_q`: bits held in the window, 0..PATTERN_W-1.
  - `state_q`: one of IDLE, FILL, ARMED.
- Shift rule, on every accepted bit (`in_valid`=1 in FILL or ARMED): `win_next = {win_q[PATTERN_W-2:0], in_bit}`.
- IDLE:
  - `en`=1 → latch `pat_q <= pattern_i`, clear `win_q` and `fill_q`, go to FILL.
  - `in_valid` is ignored in the cycle IDLE is left.
- FILL:
  - Each accepted bit shifts the window and increments `fill_q`.
  - If `fill_q == PATTERN_W-1`, go to ARMED and evaluate the match on `win_next`.
- ARMED: each accepted bit shifts the window and evaluates the match on `win_next`.
- Match condition: `win_next == pat_q` on an accepted bit that completes or keeps a full window.
  - `detect` is set to 1 for the next cycle.
  - `OVERLAP`=1: stay in ARMED.
  - `OVERLAP`=0: set `fill_q` to 0 and go to FILL. The window contents are don't-care.
- `in_valid`=0: no shift and no state change. Bubbles never break a partial match.
- `en`=0 in any state → IDLE on the next edge; `detect` goes to 0 and `count` holds.
- Changing `pattern_i` while `en`=1 has no effect until IDLE is re-entered.
- Reserved state encoding → IDLE on the next edge.

## Timing
- Reset values: `state_q`=IDLE, `win_q`=0, `fill_q`=0, `pat_q`=0, `detect`=0, `armed`=0, `count`=0.
- Reset is asynchronous on assertion, including mid-stream.
- `detect` rises on the same clk edge that samples the final matching bit and stays high exactly one cycle. Back-to-back matches give consecutive high cycles.
- First match is possible no earlier than `PATTERN_W` accepted bits after leaving IDLE.
- `armed` is registered and tracks `state_q == ARMED`.
- Counter, on the edge where `detect` is set:
  - it increments by 1 and saturates at `2^CNT_W-1`;
  - `count_clr` has priority over the increment;
  - a clear and a detect on the same edge give 0.

## Configuration
- `SEQDET_COUNT_EN` defined: the `count_clr` input and `count` output exist, with the counter behaving as above.
- Undefined: the ports are absent and no counter logic is built; `detect` and `armed` behave identically.

## Structure
- Package `seq_det_pkg`:
  - state enum `seq_state_t` {IDLE, FILL, ARMED};
  - constants `SEQ_PATTERN_W_MAX=16`, `SEQ_PATTERN_W_MIN=2`.
- One sub-module, `sat_counter`: parametrised `CNT_W`, with `inc` and `clr` inputs. It is instantiated only under `SEQDET_COUNT_EN`.
- FSM, window and compare logic stay in the top module.

## Test plan
- `PATTERN_W`=4, pattern 1101, `OVERLAP`=1, stream 1,1,0,1,1,0,1 with `in_valid` held high → `detect` pulses after bits 4 and 7.
- Same pattern and stream with `OVERLAP`=0 → one pulse, after bit 4 only.
- `PATTERN_W`=2, pattern 11, stream 1,1,1 → `OVERLAP`=1 gives 2 pulses; `OVERLAP`=0 gives 1 pulse.
- Pattern 1101 with `in_valid` low for 3 cycles between every bit → same pulse positions as the first scenario, one cycle after each matching sampled bit; `armed` rises after the 4th accepted bit.
- Assert `reset_n` low after bits 1,1,0, then release and send 1 → no `detect`; `fill_q`=1, `armed`=0.
- `SEQDET_COUNT_EN`, `CNT_W`=2, 5 matches → `count` reads 1,2,3,3,3; `count_clr` coincident with the 5th match → `count`=0.
